instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset (bits [1:0] treated as 00).
REQ-002 SHALL have parameter DEPTH, default 2, giving the instruction buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port IMemReq, output, 1, fetch request to instruction memory.
REQ-006 SHALL have port IMemAddr, output, 32, fetch address; always equals FetchPC.
REQ-007 SHALL have port IMemReady, input, 1, memory accepts the request this cycle.
REQ-008 SHALL have port IMemValid, input, 1, read data valid this cycle.
REQ-009 SHALL have port IMemRD, input, 32, instruction word returned.
REQ-010 SHALL have port Instr, output, 32, buffer head instruction to decode/immediate extension.
REQ-011 SHALL have port InstrPC, output, 32, address of Instr.
REQ-012 SHALL have port InstrValid, output, 1, buffer non-empty.
REQ-013 SHALL have port InstrReady, input, 1, decode consumes head this cycle.
REQ-014 SHALL have port Redirect, input, 1, taken branch/jump flush request.
REQ-015 SHALL have port RedirectPC, input, 32, new fetch address (bits [1:0] forced to 00).

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, DRAIN; reset state IDLE; IDLE -> FETCH unconditionally on the first edge after reset release.
REQ-017 SHALL drive IMemReq = 1 only in FETCH and only when (buffer count + outstanding) < DEPTH; IMemReq = 0 in IDLE, WAIT and DRAIN.
REQ-018 SHALL treat IMemReq && IMemReady as acceptance: capture FetchPC into ReqPC, FetchPC <= FetchPC + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), FETCH -> WAIT.
REQ-019 SHALL allow at most one outstanding request; in WAIT, IMemValid pushes {IMemRD, ReqPC} into the buffer and returns to FETCH.
REQ-020 SHALL ignore IMemValid in IDLE and FETCH (no push, no state change).
REQ-021 SHALL present the buffer head combinationally on Instr/InstrPC; when empty Instr = 32'h0000_0013 (NOP), InstrPC = 0, InstrValid = 0.
REQ-022 SHALL pop the head when InstrValid && InstrReady; InstrReady while empty has no effect.
REQ-023 SHALL keep count unchanged when a push and a pop occur in the same cycle, including when the buffer holds DEPTH-1 entries.
REQ-024 SHALL give Redirect highest priority: flush buffer (count 0), FetchPC <= {RedirectPC[31:2],2'b00}, and any same-cycle pop or push is discarded.
REQ-025 SHALL on Redirect: in FETCH without acceptance -> FETCH; in FETCH with same-cycle acceptance -> DRAIN; in WAIT without IMemValid -> DRAIN; in WAIT with IMemValid -> FETCH (response dropped); in DRAIN -> DRAIN (FetchPC updated).
REQ-026 SHALL in DRAIN discard the response on IMemValid and go to FETCH; no push.
REQ-027 SHALL have latency: request accepted at edge N, IMemValid in cycle N+k (k >= 1) -> InstrValid = 1 in the cycle after that push edge.
REQ-028 SHALL never overflow the buffer: a push always has a reserved slot per REQ-017.

Reset
REQ-029 SHALL while reset is high hold: state IDLE, FetchPC = RESET_PC, count 0, no outstanding request, IMemReq 0, IMemAddr = RESET_PC, InstrValid 0, Instr 32'h0000_0013, InstrPC 0.
REQ-030 SHALL on reset asserted mid-operation (any state, including an outstanding request) return immediately to the REQ-029 values; a memory response arriving after reset release is ignored per REQ-020.

Verification
REQ-031 SHALL cover basic fetch: reset release, IMemReady = 1, IMemValid one cycle after acceptance, InstrReady = 1 -> Instr/InstrPC sequence (RD0,0x0),(RD1,0x4),(RD2,0x8), one instruction per 2 cycles.
REQ-032 SHALL cover back-pressure: InstrReady = 0 with DEPTH = 2 -> exactly two accepted requests, then IMemReq = 0 and IMemAddr = 0x8 held; InstrReady = 1 for one cycle -> IMemReq = 1 again.
REQ-033 SHALL cover redirect in WAIT: Redirect with RedirectPC = 0x103 while outstanding -> DRAIN, late response discarded, next request IMemAddr = 0x100, buffer empty.
REQ-034 SHALL cover simultaneous events: Redirect, IMemValid and pop in one cycle -> count 0, no push, state FETCH, IMemAddr = RedirectPC.
REQ-035 SHALL cover wrap and reset: RedirectPC = 0xFFFF_FFFC -> next fetched addresses 0xFFFF_FFFC, 0x0; reset asserted in WAIT -> all outputs to REQ-029 values within the same cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch front end. Issues one request at a time to instruction
//   memory and queues the returned words with their addresses in a small FIFO
//   for decode. A redirect flushes the FIFO and restarts fetch at a new address.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   IMemReq / IMemAddr     fetch request and its address (always FetchPC)
//   IMemReady              memory accepts the request this cycle
//   IMemValid / IMemRD     response valid and instruction word
//   Instr / InstrPC        FIFO head instruction and its address (NOP / 0 when empty)
//   InstrValid             FIFO non-empty
//   InstrReady             decode consumes the head this cycle
//   Redirect / RedirectPC  flush and restart fetch at RedirectPC (word aligned)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | just out of reset, no request; moves to FETCH on the next edge
// FETCH | may request when a FIFO slot is free; waits for IMemReady
// WAIT  | one request outstanding; its response is pushed into the FIFO
// DRAIN | one request outstanding after a redirect; its response is dropped

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemValid,
  input  logic [31:0] IMemRD,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);

  localparam int          PW         = $clog2(DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   redirect_pc_a;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          outstanding;
  logic          accept;
  logic          push;
  logic          pop;

  assign redirect_pc_a = RedirectPC & 32'hFFFF_FFFC;

  always_comb begin
    state_nxt   = state;
    outstanding = (state == WAIT);
    // A slot is reserved for the outstanding response, so a push can never
    // find the FIFO full.
    IMemReq     = (state == FETCH) && ((count + CW'(outstanding)) < DEPTH_C);
    accept      = IMemReq && IMemReady;
    push        = (state == WAIT) && IMemValid && !Redirect;
    pop         = InstrValid && InstrReady && !Redirect;

    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (accept) state_nxt = Redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (IMemValid)     state_nxt = FETCH;
        else if (Redirect) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The response that arrives here is the one still owed to us, so it
        // retires the outstanding request even if a new redirect lands now.
        if (IMemValid) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC_A;
      req_pc   <= RESET_PC_A;
    end else begin
      if (accept) req_pc <= fetch_pc;
      if (Redirect)    fetch_pc <= redirect_pc_a;
      else if (accept) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (Redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Payload storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= IMemRD;
      buf_pc[wr_ptr]    <= req_pc;
    end
  end

  assign IMemAddr   = fetch_pc;
  assign InstrValid = (count != '0);
  assign Instr      = InstrValid ? buf_instr[rd_ptr] : NOP;
  assign InstrPC    = InstrValid ? buf_pc[rd_ptr]    : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit (RESET_PC = 0, DEPTH = 2).
//   Inputs are driven 2 time units after a rising edge; outputs are sampled
//   1 unit later, well away from the next edge.

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic        IMemValid;
  logic [31:0] IMemRD;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectPC;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemValid  (IMemValid),
    .IMemRD     (IMemRD),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Sample point inside the current cycle, after inputs have settled.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    IMemReady  = 1'b0;
    IMemValid  = 1'b0;
    IMemRD     = 32'h0;
    InstrReady = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
  endtask

  // Leaves the DUT in its first FETCH cycle.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   {31'b0, IMemReq},    32'h0);
    chk({tag, "_addr"},  IMemAddr,            32'h0);
    chk({tag, "_valid"}, {31'b0, InstrValid}, 32'h0);
    chk({tag, "_instr"}, Instr,               NOP);
    chk({tag, "_pc"},    InstrPC,             32'h0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    settle();
    check_reset_vals("rst");

    // Basic fetch: one instruction every two cycles.
    reset = 1'b0;
    settle();
    chk("idle_req", {31'b0, IMemReq}, 32'h0);
    step();
    IMemReady  = 1'b1;
    InstrReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("s1_req%0d", i),  {31'b0, IMemReq}, 32'h1);
      chk($sformatf("s1_addr%0d", i), IMemAddr, 32'(4 * i));
      step();
      settle();
      chk($sformatf("s1_wait_req%0d", i), {31'b0, IMemReq}, 32'h0);
      IMemValid = 1'b1;
      IMemRD    = 32'hA000_0000 + 32'(i);
      step();
      IMemValid = 1'b0;
      settle();
      chk($sformatf("s1_valid%0d", i), {31'b0, InstrValid}, 32'h1);
      chk($sformatf("s1_instr%0d", i), Instr, 32'hA000_0000 + 32'(i));
      chk($sformatf("s1_pc%0d", i),    InstrPC, 32'(4 * i));
    end

    // Back-pressure: two requests fill the FIFO, then fetch stalls at 0x8.
    do_reset();
    IMemReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("s2_req%0d", i),  {31'b0, IMemReq}, 32'h1);
      chk($sformatf("s2_addr%0d", i), IMemAddr, 32'(4 * i));
      step();
      IMemValid = 1'b1;
      IMemRD    = 32'hB000_0000 + 32'(i);
      step();
      IMemValid = 1'b0;
    end
    settle();
    chk("s2_full_req",  {31'b0, IMemReq}, 32'h0);
    chk("s2_full_addr", IMemAddr, 32'h8);
    step();
    settle();
    chk("s2_hold_req",  {31'b0, IMemReq}, 32'h0);
    chk("s2_hold_addr", IMemAddr, 32'h8);
    chk("s2_head",      Instr, 32'hB000_0000);
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    settle();
    chk("s2_resume_req",  {31'b0, IMemReq}, 32'h1);
    chk("s2_resume_addr", IMemAddr, 32'h8);
    chk("s2_head2_pc",    InstrPC, 32'h4);
    // Push and pop together with one entry held: count stays at one.
    step();
    IMemValid  = 1'b1;
    IMemRD     = 32'hB000_0002;
    InstrReady = 1'b1;
    step();
    IMemValid  = 1'b0;
    InstrReady = 1'b0;
    settle();
    chk("s2_pp_valid", {31'b0, InstrValid}, 32'h1);
    chk("s2_pp_pc",    InstrPC, 32'h8);
    chk("s2_pp_instr", Instr, 32'hB000_0002);
    chk("s2_pp_req",   {31'b0, IMemReq}, 32'h1);

    // Redirect while a request is outstanding.
    do_reset();
    IMemReady = 1'b1;
    step();
    IMemReady  = 1'b0;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0103;
    step();
    Redirect = 1'b0;
    settle();
    chk("s3_drain_req",  {31'b0, IMemReq}, 32'h0);
    chk("s3_drain_addr", IMemAddr, 32'h100);
    step();
    settle();
    chk("s3_drain2_req", {31'b0, IMemReq}, 32'h0);
    IMemValid = 1'b1;
    IMemRD    = 32'hDEAD_BEEF;
    step();
    IMemValid = 1'b0;
    settle();
    chk("s3_req",   {31'b0, IMemReq}, 32'h1);
    chk("s3_addr",  IMemAddr, 32'h100);
    chk("s3_valid", {31'b0, InstrValid}, 32'h0);

    // Redirect, response and pop in the same cycle.
    do_reset();
    IMemReady = 1'b1;
    step();
    IMemValid = 1'b1;
    IMemRD    = 32'hC000_0000;
    step();
    IMemValid = 1'b0;
    step();
    IMemReady  = 1'b0;
    IMemValid  = 1'b1;
    IMemRD     = 32'hC000_0001;
    InstrReady = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0200;
    step();
    clear_inputs();
    settle();
    chk("s4_valid", {31'b0, InstrValid}, 32'h0);
    chk("s4_instr", Instr, NOP);
    chk("s4_req",   {31'b0, IMemReq}, 32'h1);
    chk("s4_addr",  IMemAddr, 32'h200);
    // Redirect in the same cycle as acceptance goes to DRAIN.
    IMemReady  = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0300;
    step();
    clear_inputs();
    settle();
    chk("s4_drain_req",  {31'b0, IMemReq}, 32'h0);
    chk("s4_drain_addr", IMemAddr, 32'h300);
    IMemValid = 1'b1;
    step();
    IMemValid = 1'b0;
    settle();
    chk("s4_fetch_req", {31'b0, IMemReq}, 32'h1);
    chk("s4_fetch_addr", IMemAddr, 32'h300);
    chk("s4_fetch_valid", {31'b0, InstrValid}, 32'h0);

    // Address wrap, then reset while a request is outstanding.
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    step();
    Redirect = 1'b0;
    settle();
    chk("s5_addr_top", IMemAddr, 32'hFFFF_FFFC);
    IMemReady = 1'b1;
    step();
    IMemValid = 1'b1;
    IMemRD    = 32'hE000_0000;
    step();
    IMemValid = 1'b0;
    settle();
    chk("s5_addr_wrap", IMemAddr, 32'h0);
    chk("s5_head_pc",   InstrPC, 32'hFFFF_FFFC);
    step();
    reset = 1'b1;
    settle();
    check_reset_vals("s5_rst");
    step();
    reset     = 1'b0;
    IMemReady = 1'b0;
    IMemValid = 1'b1;
    IMemRD    = 32'hBAD0_0000;
    step();
    settle();
    chk("s5_late_valid", {31'b0, InstrValid}, 32'h0);
    chk("s5_late_req",   {31'b0, IMemReq}, 32'h1);
    step();
    IMemValid = 1'b0;
    settle();
    chk("s5_late_valid2", {31'b0, InstrValid}, 32'h0);
    chk("s5_late_addr",   IMemAddr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
